// File: rtl/kernel3x3_filter.sv
// ----------------------------------------------------------------------------
// kernel3x3_filter
//   Applies a programmable 3x3 convolution kernel to a stream of pixel windows.
//   The result is rounded, shifted and clamped to an unsigned pixel. A bypass
//   mode passes the centre pixel through. The pipeline has two stages: the
//   products are registered first, then the sum/round/shift/clamp result.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   in3x3_val/rdy     input window handshake
//   in3x3_data        9 pixels, p00 in the MSBs, row-major, p22 in the LSBs
//   in3x3_sof/sol/eol/eof  framing flags travelling with the window
//   out_val/rdy       output pixel handshake
//   out_data          filtered pixel
//   out_sof/sol/eol/eof    framing flags of out_data
//   cfg_wr/addr/data  coefficient write port; addr 0..8 are taps (row-major),
//                     addr 9 holds shift in data[3:0] and bypass in data[4]
// ----------------------------------------------------------------------------
module kernel3x3_filter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COEF_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      in3x3_val,
    output logic                      in3x3_rdy,
    input  logic [9*DATA_WIDTH-1:0]   in3x3_data,
    input  logic                      in3x3_sof,
    input  logic                      in3x3_sol,
    input  logic                      in3x3_eol,
    input  logic                      in3x3_eof,

    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_sof,
    output logic                      out_sol,
    output logic                      out_eol,
    output logic                      out_eof,

    input  logic                      cfg_wr,
    input  logic [3:0]                cfg_addr,
    input  logic [COEF_WIDTH-1:0]     cfg_data
);

    localparam int unsigned NTAP    = 9;
    localparam int unsigned CENTER  = 4;
    localparam int unsigned PIX_W   = DATA_WIDTH + 1;
    localparam int unsigned PROD_W  = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int unsigned SUM_W   = DATA_WIDTH + COEF_WIDTH + 5;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned FLAG_W  = 4;

    localparam logic [SHIFT_W-1:0]    DFLT_SHIFT = SHIFT_W'(4);
    localparam logic [DATA_WIDTH-1:0] PIX_MAX    = '1;

    // Reset kernel 1,2,1 / 2,4,2 / 1,2,1
    function automatic logic [COEF_WIDTH-1:0] dflt_coef(input int unsigned idx);
        case (idx)
            CENTER:         return COEF_WIDTH'(4);
            1, 3, 5, 7:     return COEF_WIDTH'(2);
            default:        return COEF_WIDTH'(1);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Configuration banks
    // ------------------------------------------------------------------
    logic [COEF_WIDTH-1:0] pend_coef [NTAP];
    logic [COEF_WIDTH-1:0] act_coef  [NTAP];
    logic [SHIFT_W-1:0]    pend_shift;
    logic [SHIFT_W-1:0]    act_shift;
    logic                  pend_bypass;
    logic                  act_bypass;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                  s1_full;
    logic [PROD_W-1:0]     s1_prod [NTAP];
    logic [DATA_WIDTH-1:0] s1_p11;
    logic [SHIFT_W-1:0]    s1_shift;
    logic                  s1_bypass;
    logic [FLAG_W-1:0]     s1_flags;

    logic                  in_acc;
    logic                  s2_adv;

    // Output stage can take a new beat when empty or being drained
    assign s2_adv    = ~out_val | out_rdy;
    assign in3x3_rdy = ~s1_full | s2_adv;
    assign in_acc    = in3x3_val & in3x3_rdy;

    // Pending bank takes every write; active bank snapshots pending on an
    // accepted sof beat, so a frame always sees one consistent kernel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NTAP; i++) begin
                pend_coef[i] <= dflt_coef(i);
                act_coef[i]  <= dflt_coef(i);
            end
            pend_shift  <= DFLT_SHIFT;
            act_shift   <= DFLT_SHIFT;
            pend_bypass <= 1'b0;
            act_bypass  <= 1'b0;
        end else begin
            if (in_acc && in3x3_sof) begin
                for (int unsigned i = 0; i < NTAP; i++) begin
                    act_coef[i] <= pend_coef[i];
                end
                act_shift  <= pend_shift;
                act_bypass <= pend_bypass;
            end
            if (cfg_wr) begin
                if (cfg_addr < 4'd9) begin
                    pend_coef[cfg_addr] <= cfg_data;
                end else if (cfg_addr == 4'd9) begin
                    pend_shift  <= cfg_data[SHIFT_W-1:0];
                    pend_bypass <= cfg_data[4];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational: products. A sof beat already uses the pending
    // bank because the active copy only lands on the same clock edge.
    // ------------------------------------------------------------------
    logic [COEF_WIDTH-1:0] eff_coef_c [NTAP];
    logic [PROD_W-1:0]     pix_ext_c  [NTAP];
    logic [PROD_W-1:0]     coef_ext_c [NTAP];
    logic [PROD_W-1:0]     prod_c     [NTAP];
    logic [SHIFT_W-1:0]    eff_shift_c;
    logic                  eff_bypass_c;

    always_comb begin
        eff_shift_c  = in3x3_sof ? pend_shift  : act_shift;
        eff_bypass_c = in3x3_sof ? pend_bypass : act_bypass;
        for (int unsigned i = 0; i < NTAP; i++) begin
            eff_coef_c[i] = in3x3_sof ? pend_coef[i] : act_coef[i];
            // Zero-extended pixel times sign-extended coefficient; the low
            // PROD_W bits of the product are the exact signed result.
            pix_ext_c[i]  = {(PROD_W-DATA_WIDTH)'(0),
                             in3x3_data[(NTAP-1-i)*DATA_WIDTH +: DATA_WIDTH]};
            coef_ext_c[i] = {{(PROD_W-COEF_WIDTH){eff_coef_c[i][COEF_WIDTH-1]}},
                             eff_coef_c[i]};
            prod_c[i]     = pix_ext_c[i] * coef_ext_c[i];
        end
    end

    // Stage 1 register: products plus the per-beat config and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full   <= 1'b0;
            for (int unsigned i = 0; i < NTAP; i++) begin
                s1_prod[i] <= '0;
            end
            s1_p11    <= '0;
            s1_shift  <= '0;
            s1_bypass <= 1'b0;
            s1_flags  <= '0;
        end else begin
            if (in_acc) begin
                s1_full   <= 1'b1;
                for (int unsigned i = 0; i < NTAP; i++) begin
                    s1_prod[i] <= prod_c[i];
                end
                s1_p11    <= in3x3_data[(NTAP-1-CENTER)*DATA_WIDTH +: DATA_WIDTH];
                s1_shift  <= eff_shift_c;
                s1_bypass <= eff_bypass_c;
                s1_flags  <= {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof};
            end else if (s2_adv) begin
                s1_full   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: sum, round, arithmetic shift, clamp, bypass
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]        sum_c;
    logic [SUM_W-1:0]        rnd_c;
    logic signed [SUM_W-1:0] rounded_c;
    logic signed [SUM_W-1:0] shifted_c;
    logic [DATA_WIDTH-1:0]   clamped_c;
    logic [DATA_WIDTH-1:0]   result_c;

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NTAP; i++) begin
            sum_c = sum_c + {{(SUM_W-PROD_W){s1_prod[i][PROD_W-1]}}, s1_prod[i]};
        end
        rnd_c     = (s1_shift == '0) ? '0 : (SUM_W'(1) << (s1_shift - SHIFT_W'(1)));
        rounded_c = sum_c + rnd_c;
        shifted_c = rounded_c >>> s1_shift;

        if (shifted_c[SUM_W-1]) begin
            clamped_c = '0;
        end else if (|shifted_c[SUM_W-2:DATA_WIDTH]) begin
            clamped_c = PIX_MAX;
        end else begin
            clamped_c = shifted_c[DATA_WIDTH-1:0];
        end

        result_c = s1_bypass ? s1_p11 : clamped_c;
    end

    // Stage 2 register: holds while the downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val  <= 1'b0;
            out_data <= '0;
            out_sof  <= 1'b0;
            out_sol  <= 1'b0;
            out_eol  <= 1'b0;
            out_eof  <= 1'b0;
        end else if (s2_adv) begin
            out_val <= s1_full;
            if (s1_full) begin
                out_data <= result_c;
                {out_sof, out_sol, out_eol, out_eof} <= s1_flags;
            end
        end
    end

endmodule

// File: tb/tb_kernel3x3_filter.sv
// ----------------------------------------------------------------------------
// tb_kernel3x3_filter
//   Directed bench for kernel3x3_filter: default kernel, Laplacian clamping,
//   config timing around sof, bypass streaming, random backpressure and
//   mid-stream reset.
// ----------------------------------------------------------------------------
module tb_kernel3x3_filter;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 5;

    logic            clk;
    logic            rst_n;
    logic            in3x3_val;
    logic            in3x3_rdy;
    logic [9*DW-1:0] in3x3_data;
    logic            in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof;
    logic            out_val;
    logic            out_rdy;
    logic [DW-1:0]   out_data;
    logic            out_sof, out_sol, out_eol, out_eof;
    logic            cfg_wr;
    logic [3:0]      cfg_addr;
    logic [CW-1:0]   cfg_data;

    int total = 0;
    int bad   = 0;

    int lap [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    int dk  [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    int          sent, recv, cyc;
    logic        stall_prev;
    logic [12:0] hold;

    kernel3x3_filter #(.DATA_WIDTH(DW), .COEF_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in3x3_val  (in3x3_val),
        .in3x3_rdy  (in3x3_rdy),
        .in3x3_data (in3x3_data),
        .in3x3_sof  (in3x3_sof),
        .in3x3_sol  (in3x3_sol),
        .in3x3_eol  (in3x3_eol),
        .in3x3_eof  (in3x3_eof),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Window with centre pixel c and all eight neighbours o
    function automatic logic [9*DW-1:0] mkwin(input logic [DW-1:0] c, input logic [DW-1:0] o);
        return {o, o, o, o, c, o, o, o, o};
    endfunction

    function automatic logic [DW-1:0] sv(input int k);
        return DW'(13 * k + 5);
    endfunction

    function automatic logic [3:0] byp_flags(input int k);
        return {k == 0, (k % 5) == 0, (k % 5) == 4, k == 9};
    endfunction

    task automatic cfg(input logic [3:0] a, input logic [CW-1:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr   = 1'b0;
    endtask

    // One isolated beat on an empty pipeline with out_rdy high, optional
    // concurrent config write; checks exact 2-cycle latency and the result.
    task automatic run_one(input string tag, input logic [9*DW-1:0] win, input logic sof,
                           input logic [DW-1:0] expv, input logic cw,
                           input logic [3:0] ca, input logic [CW-1:0] cd);
        out_rdy    = 1'b1;
        in3x3_val  = 1'b1;
        in3x3_data = win;
        in3x3_sof  = sof;
        in3x3_sol  = 1'b0;
        in3x3_eol  = 1'b0;
        in3x3_eof  = 1'b0;
        cfg_wr     = cw;
        cfg_addr   = ca;
        cfg_data   = cd;
        #1;
        check({tag, "_rdy"}, in3x3_rdy, 1);
        tick();
        in3x3_val = 1'b0;
        in3x3_sof = 1'b0;
        cfg_wr    = 1'b0;
        check({tag, "_lat1"}, out_val, 0);
        tick();
        check({tag, "_val"}, out_val, 1);
        check({tag, "_data"}, out_data, expv);
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        in3x3_val  = 1'b0;
        in3x3_data = '0;
        in3x3_sof  = 1'b0;
        in3x3_sol  = 1'b0;
        in3x3_eol  = 1'b0;
        in3x3_eof  = 1'b0;
        out_rdy    = 1'b1;
        cfg_wr     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        #2;
        check("reset_outval", out_val, 0);
        check("reset_outdata", out_data, 0);
        check("reset_flags", {out_sof, out_sol, out_eol, out_eof}, 0);
        check("reset_rdy", in3x3_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Default kernel
        run_one("dflt_255", mkwin(8'd255, 8'd255), 1'b1, 8'd255, 1'b0, 4'd0, 5'd0);
        run_one("dflt_c100", mkwin(8'd100, 8'd0), 1'b0, 8'd25, 1'b0, 4'd0, 5'd0);

        // Laplacian, shift 0, loaded into pending only
        for (int i = 0; i < 9; i++) cfg(4'(i), CW'(lap[i]));
        cfg(4'd9, 5'h00);
        run_one("pend_only", mkwin(8'd100, 8'd0), 1'b0, 8'd25, 1'b0, 4'd0, 5'd0);
        run_one("lap_hi", mkwin(8'd200, 8'd10), 1'b1, 8'd255, 1'b0, 4'd0, 5'd0);
        run_one("lap_lo", mkwin(8'd0, 8'd10), 1'b0, 8'd0, 1'b0, 4'd0, 5'd0);

        // Mid-frame write of coef4=0 does not touch the running frame
        cfg(4'd4, 5'd0);
        run_one("midframe", mkwin(8'd30, 8'd0), 1'b0, 8'd120, 1'b0, 4'd0, 5'd0);
        // Write coinciding with sof: active gets coef4=0, pending becomes 2
        run_one("sof_wr", mkwin(8'd30, 8'd0), 1'b1, 8'd0, 1'b1, 4'd4, 5'd2);
        run_one("after_sof", mkwin(8'd30, 8'd0), 1'b0, 8'd0, 1'b0, 4'd0, 5'd0);
        run_one("next_sof", mkwin(8'd30, 8'd0), 1'b1, 8'd60, 1'b0, 4'd0, 5'd0);

        // Bypass: 10 back-to-back beats, centre pixel and flags pass through
        cfg(4'd9, 5'h10);
        out_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) begin
                check("byp_val", out_val, 1);
                check("byp_data", out_data, DW'(7 * (c - 2) + 11));
                check("byp_flags", {out_sof, out_sol, out_eol, out_eof}, byp_flags(c - 2));
            end
            if (c < 10) begin
                in3x3_val  = 1'b1;
                in3x3_data = mkwin(DW'(7 * c + 11), 8'd200);
                {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof} = byp_flags(c);
            end else begin
                in3x3_val = 1'b0;
                {in3x3_sof, in3x3_sol, in3x3_eol, in3x3_eof} = 4'b0;
            end
            tick();
        end
        check("byp_drain", out_val, 0);

        // Restore default kernel; unused addresses must be ignored
        for (int i = 0; i < 9; i++) cfg(4'(i), CW'(dk[i]));
        cfg(4'd9, 5'h04);
        cfg(4'd10, 5'h10);
        cfg(4'd15, 5'h1F);

        // 20 beats with random backpressure; uniform window v yields v
        sent = 0;
        recv = 0;
        stall_prev = 1'b0;
        hold = '0;
        for (cyc = 0; cyc < 400 && recv < 20; cyc++) begin
            if (stall_prev)
                check("stall_hold", {out_val, out_data, out_sof, out_sol, out_eol, out_eof}, hold);
            out_rdy = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                in3x3_val  = 1'b1;
                in3x3_data = mkwin(sv(sent), sv(sent));
                in3x3_sof  = (sent == 0);
                in3x3_sol  = 1'b0;
                in3x3_eol  = 1'b0;
                in3x3_eof  = (sent == 19);
            end else begin
                in3x3_val = 1'b0;
                in3x3_sof = 1'b0;
                in3x3_eof = 1'b0;
            end
            #1;
            if (out_val && out_rdy) begin
                check("stream_beat", {out_data, out_sof, out_sol, out_eol, out_eof},
                      {sv(recv), recv == 0, 1'b0, 1'b0, recv == 19});
                recv++;
            end
            if (in3x3_val && in3x3_rdy) sent++;
            stall_prev = out_val && !out_rdy;
            hold = {out_val, out_data, out_sof, out_sol, out_eol, out_eof};
            tick();
        end
        in3x3_val = 1'b0;
        in3x3_sof = 1'b0;
        in3x3_eof = 1'b0;
        check("stream_count", recv, 20);
        out_rdy = 1'b1;
        tick();
        tick();
        check("stream_nodup", out_val, 0);

        // Reset with two beats in flight under a non-default (bypass) config
        cfg(4'd9, 5'h10);
        in3x3_val  = 1'b1;
        in3x3_data = mkwin(8'd100, 8'd0);
        in3x3_sof  = 1'b1;
        tick();
        in3x3_sof  = 1'b0;
        tick();
        in3x3_val  = 1'b0;
        check("inflight_val", out_val, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_val", out_val, 0);
        check("rst_async_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_rdy", in3x3_rdy, 1);
        tick();
        tick();
        tick();
        check("rst_no_output", out_val, 0);
        run_one("rst_dflt", mkwin(8'd100, 8'd0), 1'b1, 8'd25, 1'b0, 4'd0, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
